led_pattern_engine: RTL and testbench

Parametrised LED pattern generator for the board-level demo designs. It takes debounced one-cycle button pulses and drives an N-wide LED bank in one of four patterns (bounce, rotate, fill bar, blink). Step speed is selectable from a set of binary-scaled periods. It sits between the debounce block and the LED pins and replaces the fixed 8-LED, 3-speed chaser.

---
 rtl/led_pattern_if.sv | 24 ++
 rtl/led_pattern_engine.sv | 143 ++++++++++++++
 tb/tb_led_pattern_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/led_pattern_if.sv
// Control and LED-drive bundle between the button/debounce side and the pattern engine.
// The master drives the step pulses and pause; the slave (engine) drives LEDs and status.
interface led_pattern_if #(
    parameter int NUM_LEDS = 8,
    parameter int SPEED_W  = 2
);
    logic                speed_step;
    logic                mode_step;
    logic                pause;
    logic [NUM_LEDS-1:0] led_out;
    logic                tick;
    logic [SPEED_W-1:0]  speed_sel;
    logic [1:0]          mode_sel;

    modport master (
        output speed_step, mode_step, pause,
        input  led_out, tick, speed_sel, mode_sel
    );

    modport slave (
        input  speed_step, mode_step, pause,
        output led_out, tick, speed_sel, mode_sel
    );
endinterface

// File: rtl/led_pattern_engine.sv
// N-wide LED pattern generator: bounce / rotate / fill bar / blink, stepped by a
// binary-scaled period counter. All outputs come straight from registers.
module led_pattern_engine #(
    parameter int CLK_FREQ_HZ    = 10_000_000,
    parameter int BASE_PERIOD_MS = 1000,
    parameter int NUM_LEDS       = 8,
    parameter int NUM_SPEEDS     = 4,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic          clk,
    input  logic          rst,
    led_pattern_if.slave  bus
);
    localparam int unsigned P0      = CLK_FREQ_HZ / 1000 * BASE_PERIOD_MS;
    localparam int          CNT_W   = $clog2(P0);
    localparam int          SPEED_W = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
    localparam int          POS_W   = $clog2(NUM_LEDS);
    localparam int          LVL_W   = $clog2(NUM_LEDS + 1);
    localparam logic [NUM_LEDS-1:0] POL = {NUM_LEDS{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        M_BOUNCE = 2'd0,
        M_ROTATE = 2'd1,
        M_FILL   = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    mode_t               mode_q, mode_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_dn_q, dir_dn_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                phase_q, phase_d;
    logic                tick_q, tick_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic [CNT_W-1:0]    last_cnt;
    logic                wrap, step_any, adv;
    logic [NUM_LEDS-1:0] lit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= M_BOUNCE;
            speed_q  <= '0;
            cnt_q    <= '0;
            pos_q    <= '0;
            dir_dn_q <= 1'b0;
            level_q  <= '0;
            phase_q  <= 1'b0;
            tick_q   <= 1'b0;
            led_q    <= POL ^ NUM_LEDS'(1);
        end else begin
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            dir_dn_q <= dir_dn_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
            tick_q   <= tick_d;
            led_q    <= led_d;
        end
    end

    // A step pulse pre-empts a wrap in the same cycle: clear only, no advance.
    always_comb begin
        last_cnt = CNT_W'((P0 >> speed_q) - 1);
        wrap     = (cnt_q == last_cnt);
        step_any = bus.speed_step | bus.mode_step;
        adv      = wrap & ~bus.pause & ~step_any;
        tick_d   = adv;

        if (step_any)       cnt_d = '0;
        else if (bus.pause) cnt_d = cnt_q;
        else if (wrap)      cnt_d = '0;
        else                cnt_d = cnt_q + CNT_W'(1);

        speed_d = speed_q;
        if (bus.speed_step)
            speed_d = (speed_q == SPEED_W'(NUM_SPEEDS - 1)) ? '0 : speed_q + SPEED_W'(1);
    end

    // Mode / pattern state machine.
    always_comb begin
        mode_d   = mode_q;
        pos_d    = pos_q;
        dir_dn_d = dir_dn_q;
        level_d  = level_q;
        phase_d  = phase_q;

        if (bus.mode_step) begin
            mode_d   = mode_t'(mode_q + 2'd1);
            pos_d    = '0;
            dir_dn_d = 1'b0;
            level_d  = '0;
            phase_d  = 1'b0;
        end else if (adv) begin
            case (mode_q)
                M_BOUNCE: begin
                    if (!dir_dn_q) begin
                        if (pos_q == POS_W'(NUM_LEDS - 1)) begin
                            pos_d    = POS_W'(NUM_LEDS - 2);
                            dir_dn_d = 1'b1;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d    = POS_W'(1);
                            dir_dn_d = 1'b0;
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                M_ROTATE: pos_d   = (pos_q == POS_W'(NUM_LEDS - 1)) ? '0 : pos_q + POS_W'(1);
                M_FILL:   level_d = (level_q == LVL_W'(NUM_LEDS)) ? '0 : level_q + LVL_W'(1);
                M_BLINK:  phase_d = ~phase_q;
                default:  ;
            endcase
        end
    end

    // LED image is rendered from next-state so LEDs and tick change on the same edge.
    always_comb begin
        lit = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_d)
                M_BOUNCE, M_ROTATE: lit[i] = (i == int'(pos_d));
                M_FILL:             lit[i] = (i < int'(level_d));
                M_BLINK:            lit[i] = phase_d;
                default:            lit[i] = 1'b0;
            endcase
        end
        led_d = lit ^ POL;
    end

    assign bus.led_out   = led_q;
    assign bus.tick      = tick_q;
    assign bus.speed_sel = speed_q;
    assign bus.mode_sel  = mode_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: N=4, speeds P=10,5,2, active-low LEDs.
module tb_led_pattern_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    led_pattern_if #(.NUM_LEDS(4), .SPEED_W(2)) bus ();

    led_pattern_engine #(
        .CLK_FREQ_HZ(10_000), .BASE_PERIOD_MS(1), .NUM_LEDS(4),
        .NUM_SPEEDS(3), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the next tick, check its distance in cycles and the LED image it brings.
    task automatic wait_tick(input string tag, input int exp_cyc, input int exp_led);
        int cyc = 0;
        bit got = 0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.tick) got = 1;
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
        else begin
            check({tag, "_cyc"}, cyc, exp_cyc);
            check({tag, "_led"}, int'(bus.led_out), exp_led);
        end
    endtask

    task automatic pulse_speed();
        bus.speed_step = 1'b1;
        edges(1);
        bus.speed_step = 1'b0;
    endtask

    task automatic pulse_mode();
        bus.mode_step = 1'b1;
        edges(1);
        bus.mode_step = 1'b0;
    endtask

    int bounce_seq[7] = '{'hD, 'hB, 'h7, 'hB, 'hD, 'hE, 'hD};
    int rot_seq[4]    = '{'hD, 'hB, 'h7, 'hE};
    int fill_seq[5]   = '{'hE, 'hC, 'h8, 'h0, 'hF};
    int blink_seq[2]  = '{'h0, 'hF};
    int pause_ticks;

    initial begin
        bus.speed_step = 1'b0;
        bus.mode_step  = 1'b0;
        bus.pause      = 1'b0;
        edges(3);
        check("rst_led",   int'(bus.led_out), 'hE);
        check("rst_tick",  int'(bus.tick), 0);
        check("rst_mode",  int'(bus.mode_sel), 0);
        check("rst_speed", int'(bus.speed_sel), 0);
        @(negedge clk);
        rst = 1'b1;

        // bounce at P=10
        foreach (bounce_seq[k]) wait_tick($sformatf("bounce%0d", k), 10, bounce_seq[k]);

        // speed_step at counter=7 restarts the period
        edges(7);
        pulse_speed();
        check("spd1", int'(bus.speed_sel), 1);
        wait_tick("spd1_tick", 5, 'hB);
        pulse_speed();
        check("spd2", int'(bus.speed_sel), 2);
        pulse_speed();
        check("spd_wrap", int'(bus.speed_sel), 0);

        // rotate, fill, blink at P=10
        pulse_mode();
        check("rot_mode", int'(bus.mode_sel), 1);
        check("rot_init", int'(bus.led_out), 'hE);
        check("rot_notick", int'(bus.tick), 0);
        foreach (rot_seq[k]) wait_tick($sformatf("rot%0d", k), 10, rot_seq[k]);
        pulse_mode();
        check("fill_mode", int'(bus.mode_sel), 2);
        check("fill_init", int'(bus.led_out), 'hF);
        foreach (fill_seq[k]) wait_tick($sformatf("fill%0d", k), 10, fill_seq[k]);
        pulse_mode();
        check("blink_mode", int'(bus.mode_sel), 3);
        check("blink_init", int'(bus.led_out), 'hF);
        foreach (blink_seq[k]) wait_tick($sformatf("blink%0d", k), 10, blink_seq[k]);

        // pause at counter=4 for 23 cycles, resume from the held count
        edges(4);
        bus.pause = 1'b1;
        pause_ticks = 0;
        for (int i = 0; i < 23; i++) begin
            edges(1);
            if (bus.tick) pause_ticks++;
        end
        check("pause_ticks", pause_ticks, 0);
        bus.pause = 1'b0;
        wait_tick("pause_resume", 6, 'h0);

        // mode_step is honoured while paused and clears the counter
        edges(3);
        bus.pause = 1'b1;
        pulse_mode();
        check("pmode_mode", int'(bus.mode_sel), 0);
        check("pmode_led", int'(bus.led_out), 'hE);
        edges(5);
        check("pmode_hold", int'(bus.tick), 0);
        bus.pause = 1'b0;
        wait_tick("pmode_tick", 10, 'hD);

        // both step pulses on the wrap cycle: no tick, both advance
        edges(9);
        bus.speed_step = 1'b1;
        bus.mode_step  = 1'b1;
        edges(1);
        bus.speed_step = 1'b0;
        bus.mode_step  = 1'b0;
        check("both_tick", int'(bus.tick), 0);
        check("both_speed", int'(bus.speed_sel), 1);
        check("both_mode", int'(bus.mode_sel), 1);
        check("both_led", int'(bus.led_out), 'hE);
        wait_tick("both_next", 5, 'hD);

        // async reset mid-fill at level 3
        pulse_mode();
        check("f2_init", int'(bus.led_out), 'hF);
        wait_tick("f2_l1", 5, 'hE);
        wait_tick("f2_l2", 5, 'hC);
        wait_tick("f2_l3", 5, 'h8);
        edges(2);
        rst = 1'b0;
        #1;
        check("arst_led",   int'(bus.led_out), 'hE);
        check("arst_mode",  int'(bus.mode_sel), 0);
        check("arst_speed", int'(bus.speed_sel), 0);
        check("arst_tick",  int'(bus.tick), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_tick("arst_restart", 10, 'hD);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
